branch_resolve_unit: RTL and testbench

//   Parametrised successor to the combinational branch-condition block.

---
 rtl/branch_resolve_unit.sv | 175 +++++++++++++++++
 tb/tb_branch_resolve_unit.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/branch_resolve_unit.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// branch_resolve_unit
//
// Purpose:
//   Resolves branch conditions in EX from the ALU result.
//   Trains a direct-mapped table of 2-bit saturating counters (BHT) that
//   the fetch stage reads for its predictions.
//   Compares the resolved direction with the fetch-time prediction.
//   On a mispredict, raises a pipeline flush that lasts FLUSH_CYCLES cycles.
//
// Ports:
//   clk            clock, all state updates on the rising edge
//   reset          synchronous, active-high
//   pred_idx       fetch-side BHT lookup index
//   pred_taken     MSB of BHT[pred_idx], combinational read
//   br_valid       a branch is present in EX this cycle
//   br_sel         000 jump/jr, 001 beq, 010 bne, 011 bgt, 100 blt, others none
//   alu_out        ALU result used for the condition test
//   br_idx         BHT index of the branch in EX
//   br_pred_taken  prediction made at fetch for this branch
//   res_valid      registered one-cycle pulse, resolution valid
//   res_taken      registered resolved direction, holds between resolutions
//   mispredict     registered one-cycle pulse, res_taken != br_pred_taken
//   flush          high while the flush counter is nonzero
// ---------------------------------------------------------------------------
module branch_resolve_unit #(
    parameter int DATA_W       = 32,
    parameter int BHT_IDX_W    = 4,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [BHT_IDX_W-1:0] pred_idx,
    output logic                 pred_taken,
    input  logic                 br_valid,
    input  logic [2:0]           br_sel,
    input  logic [DATA_W-1:0]    alu_out,
    input  logic [BHT_IDX_W-1:0] br_idx,
    input  logic                 br_pred_taken,
    output logic                 res_valid,
    output logic                 res_taken,
    output logic                 mispredict,
    output logic                 flush
);

    localparam int BHT_DEPTH = 2 ** BHT_IDX_W;
    localparam int CNT_W     = $clog2(FLUSH_CYCLES + 1);

    localparam logic [2:0] SEL_JUMP = 3'b000;
    localparam logic [2:0] SEL_BEQ  = 3'b001;
    localparam logic [2:0] SEL_BNE  = 3'b010;
    localparam logic [2:0] SEL_BGT  = 3'b011;
    localparam logic [2:0] SEL_BLT  = 3'b100;

    logic [1:0]       bht [BHT_DEPTH];
    logic [CNT_W-1:0] flushCnt;

    logic             isZero;
    logic             isNeg;
    logic             condTaken;
    logic             isConditional;
    logic             accept;
    logic             wrongGuess;
    logic [1:0]       curCounter;
    logic [1:0]       nextCounter;

    // The fetch stage sees the stored counter directly.
    // A write in this cycle therefore only becomes visible after the edge.
    assign pred_taken = bht[pred_idx][1];

    // Flush is derived from the counter, so it rises at the same edge that loads it.
    assign flush = (flushCnt != '0);

    // While a flush is draining, whatever sits in EX is a wrong-path
    // instruction and must neither resolve nor train the table.
    assign accept = br_valid && !flush;

    assign isZero = (alu_out == '0);
    assign isNeg  = alu_out[DATA_W-1];

    // Condition evaluation from the ALU result.
    // Signed greater-than zero means the value is neither negative nor zero.
    // Only the conditional branches (beq..blt) are allowed to train the BHT.
    // Jumps are always taken, but they would only pollute the counters.
    always_comb begin
        condTaken     = 1'b0;
        isConditional = 1'b0;
        case (br_sel)
            SEL_JUMP: condTaken = 1'b1;
            SEL_BEQ: begin
                condTaken     = isZero;
                isConditional = 1'b1;
            end
            SEL_BNE: begin
                condTaken     = !isZero;
                isConditional = 1'b1;
            end
            SEL_BGT: begin
                condTaken     = !isNeg && !isZero;
                isConditional = 1'b1;
            end
            SEL_BLT: begin
                condTaken     = isNeg;
                isConditional = 1'b1;
            end
            default: begin
                condTaken     = 1'b0;
                isConditional = 1'b0;
            end
        endcase
    end

    assign wrongGuess = (condTaken != br_pred_taken);

    // Saturating 2-bit counter step for the entry the EX branch maps to.
    // The counter moves toward 11 when taken and toward 00 when not taken.
    always_comb begin
        curCounter  = bht[br_idx];
        nextCounter = curCounter;
        if (condTaken) begin
            if (curCounter != 2'b11) begin
                nextCounter = curCounter + 2'b01;
            end
        end else begin
            if (curCounter != 2'b00) begin
                nextCounter = curCounter - 2'b01;
            end
        end
    end

    // Resolution outputs are registered one cycle after accept.
    // res_taken deliberately holds its last value when nothing resolves,
    // so consumers may keep looking at the most recent outcome.
    always_ff @(posedge clk) begin
        if (reset) begin
            res_valid  <= 1'b0;
            res_taken  <= 1'b0;
            mispredict <= 1'b0;
        end else begin
            res_valid  <= accept;
            mispredict <= accept && wrongGuess;
            if (accept) begin
                res_taken <= condTaken;
            end
        end
    end

    // Flush counter.
    // It is loaded at the same edge that raises mispredict and then counts down to zero.
    // No new mispredict can load it mid-flush, because accept is blocked while it is nonzero.
    always_ff @(posedge clk) begin
        if (reset) begin
            flushCnt <= '0;
        end else if (accept && wrongGuess) begin
            flushCnt <= CNT_W'(FLUSH_CYCLES);
        end else if (flushCnt != '0) begin
            flushCnt <= flushCnt - CNT_W'(1);
        end
    end

    // Branch history table.
    // Every entry starts weakly not-taken.
    // An entry is only written for accepted conditional branches.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < BHT_DEPTH; i++) begin
                bht[i] <= 2'b01;
            end
        end else if (accept && isConditional) begin
            bht[br_idx] <= nextCounter;
        end
    end

endmodule

// File: tb/tb_branch_resolve_unit.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// tb_branch_resolve_unit
//
// Purpose:
//   Directed testbench for branch_resolve_unit using the default parameters
//   (DATA_W=32, BHT_IDX_W=4, FLUSH_CYCLES=2).
//   Expected values are hand-computed from the behaviour of a 2-bit saturating
//   BHT with 01 reset state and a two-cycle flush.
// ---------------------------------------------------------------------------
module tb_branch_resolve_unit;

    logic        clk;
    logic        reset;
    logic [3:0]  pred_idx;
    logic        pred_taken;
    logic        br_valid;
    logic [2:0]  br_sel;
    logic [31:0] alu_out;
    logic [3:0]  br_idx;
    logic        br_pred_taken;
    logic        res_valid;
    logic        res_taken;
    logic        mispredict;
    logic        flush;

    int compareCount;
    int mismatchCount;

    branch_resolve_unit #(
        .DATA_W      (32),
        .BHT_IDX_W   (4),
        .FLUSH_CYCLES(2)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .pred_idx     (pred_idx),
        .pred_taken   (pred_taken),
        .br_valid     (br_valid),
        .br_sel       (br_sel),
        .alu_out      (alu_out),
        .br_idx       (br_idx),
        .br_pred_taken(br_pred_taken),
        .res_valid    (res_valid),
        .res_taken    (res_taken),
        .mispredict   (mispredict),
        .flush        (flush)
    );

    // Free-running clock with a 10 ns period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Single comparison point.
    // It counts the comparison and reports any difference.
    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        compareCount++;
        if (actual !== expected) begin
            mismatchCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
        end
    endtask

    // Advance to just after the next rising edge so outputs are stable.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Look up the fetch-side prediction for one index.
    task automatic checkPred(input string tag, input logic [3:0] idx, input logic expected);
        pred_idx = idx;
        #1;
        checkOutput(tag, {31'b0, pred_taken}, {31'b0, expected});
    endtask

    // Present one branch in EX for exactly one edge.
    // br_valid is dropped again right after that edge.
    task automatic applyStimulus(input logic [2:0] sel, input logic [31:0] alu,
                                 input logic [3:0] idx, input logic predTaken);
        br_valid      = 1'b1;
        br_sel        = sel;
        alu_out       = alu;
        br_idx        = idx;
        br_pred_taken = predTaken;
        step();
        br_valid = 1'b0;
    endtask

    // Check the registered resolution triple in one go.
    task automatic checkResult(input string tag, input logic expValid,
                               input logic expTaken, input logic expMis);
        checkOutput({tag, ".res_valid"}, {31'b0, res_valid}, {31'b0, expValid});
        checkOutput({tag, ".res_taken"}, {31'b0, res_taken}, {31'b0, expTaken});
        checkOutput({tag, ".mispredict"}, {31'b0, mispredict}, {31'b0, expMis});
    endtask

    initial begin
        compareCount  = 0;
        mismatchCount = 0;
        reset         = 1'b1;
        pred_idx      = '0;
        br_valid      = 1'b0;
        br_sel        = 3'b111;
        alu_out       = '0;
        br_idx        = '0;
        br_pred_taken = 1'b0;

        // Reset held for two cycles, then walk every index while still in reset.
        step();
        step();
        checkResult("reset", 1'b0, 1'b0, 1'b0);
        checkOutput("reset.flush", {31'b0, flush}, 32'd0);
        for (int i = 0; i < 16; i++) begin
            pred_idx = 4'(i);
            step();
            checkOutput($sformatf("reset.pred[%0d]", i), {31'b0, pred_taken}, 32'd0);
        end
        reset = 1'b0;
        step();

        // beq taken on idx 3 against a not-taken prediction.
        // Expect a mispredict and a two-cycle flush, with BHT[3] going 01 -> 10.
        applyStimulus(3'b001, 32'd0, 4'd3, 1'b0);
        checkResult("beqMis", 1'b1, 1'b1, 1'b1);
        checkOutput("beqMis.flush1", {31'b0, flush}, 32'd1);
        checkPred("beqMis.bht3", 4'd3, 1'b1);

        // A blt arrives during the flush.
        // It must be dropped: no result and no training.
        br_valid      = 1'b1;
        br_sel        = 3'b100;
        alu_out       = 32'hFFFF_FFFF;
        br_idx        = 4'd3;
        br_pred_taken = 1'b0;
        step();
        checkResult("flushDrop1", 1'b0, 1'b1, 1'b0);
        checkOutput("flushDrop.flush2", {31'b0, flush}, 32'd1);
        step();
        br_valid = 1'b0;
        checkOutput("flushDrop2.res_valid", {31'b0, res_valid}, 32'd0);
        checkOutput("flushEnd.flush", {31'b0, flush}, 32'd0);

        // BHT[3] must still be 10.
        // A not-taken beq then takes it to 01, so the prediction reads 0.
        // Had the dropped blt trained it to 11, this beq would leave it at 10.
        applyStimulus(3'b001, 32'd5, 4'd3, 1'b0);
        checkResult("beqNt", 1'b1, 1'b0, 1'b0);
        checkPred("beqNt.bht3", 4'd3, 1'b0);

        // bgt taken on idx 5 with prediction 0 is a mispredict (01 -> 10).
        applyStimulus(3'b011, 32'd1, 4'd5, 1'b0);
        checkResult("bgt1", 1'b1, 1'b1, 1'b1);
        step();
        step();
        checkOutput("bgt1.flushDone", {31'b0, flush}, 32'd0);

        // Three back-to-back correctly predicted taken bgt.
        // The counter saturates at 11.
        applyStimulus(3'b011, 32'd1, 4'd5, 1'b1);
        checkResult("bgt2", 1'b1, 1'b1, 1'b0);
        applyStimulus(3'b011, 32'd1, 4'd5, 1'b1);
        checkResult("bgt3", 1'b1, 1'b1, 1'b0);
        applyStimulus(3'b011, 32'd1, 4'd5, 1'b1);
        checkResult("bgt4", 1'b1, 1'b1, 1'b0);
        checkOutput("bgt4.flush", {31'b0, flush}, 32'd0);
        checkPred("bgt4.bht5", 4'd5, 1'b1);

        // One not-taken bgt moves the counter from 11 to 10.
        // The prediction stays 1, and the outcome is a mispredict.
        applyStimulus(3'b011, 32'd0, 4'd5, 1'b1);
        checkResult("bgtNt", 1'b1, 1'b0, 1'b1);
        checkPred("bgtNt.bht5", 4'd5, 1'b1);
        step();
        step();

        // Negative bgt operand resolves not-taken.
        // Correctly predicted, so there is no mispredict.
        applyStimulus(3'b011, 32'h8000_0000, 4'd6, 1'b0);
        checkResult("bgtNeg", 1'b1, 1'b0, 1'b0);

        // Collision on idx 7.
        // The prediction shows the old value in the update cycle and the new value after it.
        pred_idx      = 4'd7;
        br_valid      = 1'b1;
        br_sel        = 3'b001;
        alu_out       = 32'd0;
        br_idx        = 4'd7;
        br_pred_taken = 1'b0;
        #1;
        checkOutput("collide.before", {31'b0, pred_taken}, 32'd0);
        step();
        br_valid = 1'b0;
        checkOutput("collide.after", {31'b0, pred_taken}, 32'd1);
        step();
        step();

        // bne on zero is not taken and correctly predicted.
        applyStimulus(3'b010, 32'd0, 4'd9, 1'b0);
        checkResult("bneNt", 1'b1, 1'b0, 1'b0);

        // A jump is always taken, but it never trains the table.
        // BHT[3] sits at 01, so any training would flip its prediction.
        applyStimulus(3'b000, 32'd0, 4'd3, 1'b1);
        checkResult("jump", 1'b1, 1'b1, 1'b0);
        checkPred("jump.bht3", 4'd3, 1'b0);

        // The reserved selector 101 resolves as never taken.
        applyStimulus(3'b101, 32'd0, 4'd3, 1'b0);
        checkResult("sel101", 1'b1, 1'b0, 1'b0);

        // Cause a flush, then reset in its first cycle.
        // The flush must end at the next edge, and the BHT must be reinitialised.
        applyStimulus(3'b001, 32'd0, 4'd12, 1'b0);
        checkResult("preReset", 1'b1, 1'b1, 1'b1);
        checkOutput("preReset.flush", {31'b0, flush}, 32'd1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        checkOutput("midFlushReset.flush", {31'b0, flush}, 32'd0);
        checkResult("midFlushReset", 1'b0, 1'b0, 1'b0);
        checkPred("midFlushReset.bht12", 4'd12, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
        $finish;
    end

endmodule
